// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - icache/dcache miss arbiter driving a 4-beat 64-bit burst memory port
//
// Accepts 256-bit line requests from the icache (read only) and the dcache
// (read or writeback), grants one at a time with alternating priority on
// conflict, and serialises each line into four 64-bit memory beats.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_pmem_*          icache line-read request / line + one-cycle resp
//   d_pmem_*          dcache line read/writeback request / line + one-cycle resp
//   mem_read/write    burst strobes, held for the whole burst
//   mem_address       line-aligned burst address
//   mem_wdata         current write beat
//   mem_rdata         current read beat
//   mem_resp          one strobe per accepted beat

module cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [63:0]  mem_wdata,
    input  logic [63:0]  mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [255:0] line_q, line_d;
    logic [255:0] wdata_q, wdata_d;
    logic [26:0]  addr_q, addr_d;
    // grant/last_grant: 0 = icache, 1 = dcache
    logic         grant_q, grant_d;
    logic         last_grant_q, last_grant_d;
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic         i_resp_q, i_resp_d;
    logic         d_resp_q, d_resp_d;

    logic i_req;
    logic d_req;
    logic unused_addr_bits;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
    // Low address bits are discarded: bursts are always line aligned.
    assign unused_addr_bits = ^{i_pmem_address[4:0], d_pmem_address[4:0]};

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_d       = line_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                // icache wins when alone, or on conflict if dcache went last.
                if (i_req && (!d_req || last_grant_q)) begin
                    state_d = I_READ;
                    addr_d  = i_pmem_address[31:5];
                    grant_d = 1'b0;
                    beat_d  = 2'd0;
                end else if (d_req) begin
                    addr_d  = d_pmem_address[31:5];
                    grant_d = 1'b1;
                    beat_d  = 2'd0;
                    if (d_pmem_write) begin
                        state_d = D_WRITE;
                        wdata_d = d_pmem_wdata;
                    end else begin
                        state_d = D_READ;
                    end
                end
            end
            I_READ, D_READ: begin
                if (mem_resp) begin
                    line_d[{beat_q, 6'b0} +: 64] = mem_rdata;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            D_WRITE: begin
                if (mem_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes and responses are registered off the next state so they
        // line up exactly with the state they describe.
        mem_read_d  = (state_d == I_READ) || (state_d == D_READ);
        mem_write_d = (state_d == D_WRITE);
        i_resp_d    = (state_d == DONE) && !grant_d;
        d_resp_d    = (state_d == DONE) && grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            line_q       <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = (mem_read_q || mem_write_q) ? {addr_q, 5'b0} : 32'd0;
    assign mem_wdata    = mem_write_q ? wdata_q[{beat_q, 6'b0} +: 64] : 64'd0;
    assign i_pmem_resp  = i_resp_q;
    assign d_pmem_resp  = d_resp_q;
    assign i_pmem_rdata = line_q;
    assign d_pmem_rdata = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard testbench for cache_arbiter

module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // side: 0 = icache read, 1 = dcache read, 2 = dcache writeback
    typedef struct {
        int          side;
        logic [31:0] addr;
        logic [255:0] line;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int side, input logic [31:0] addr, input logic [255:0] line);
        exp_t e;
        e.side = side;
        e.addr = addr;
        e.line = line;
        sb.push_back(e);
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] b0, input logic [63:0] b1,
                                             input logic [63:0] b2, input logic [63:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Memory model and scoreboard consumer: waits for the next burst, plays
    // four beats (gap idle cycles before each), then scores the response.
    task automatic serve(input int gap, input bit keep);
        exp_t         e;
        int           waitn;
        logic         exp_rd;
        logic [31:0]  exp_addr;
        logic [255:0] rd;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL serve: scoreboard empty, required an expected transaction");
            return;
        end
        e        = sb.pop_front();
        exp_rd   = (e.side != 2);
        exp_addr = {e.addr[31:5], 5'b0};
        waitn    = 0;
        while (!(mem_read || mem_write) && waitn < 40) begin
            tick();
            waitn++;
        end
        total++;
        if (!(mem_read || mem_write)) begin
            $display("FAIL grant_timeout side=%0d: no burst after %0d cycles, required one", e.side, waitn);
            return;
        end else passed++;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g <= gap; g++) begin
                total++;
                if (mem_read !== exp_rd || mem_write !== !exp_rd || mem_address !== exp_addr) begin
                    $display("FAIL burst_hold side=%0d beat=%0d: rd=%b wr=%b addr=%h, required rd=%b wr=%b addr=%h",
                             e.side, k, mem_read, mem_write, mem_address, exp_rd, !exp_rd, exp_addr);
                end else passed++;
                if (g < gap) begin
                    mem_resp = 1'b0;
                    tick();
                end
            end
            if (!exp_rd) begin
                total++;
                if (mem_wdata !== e.line[64*k +: 64]) begin
                    $display("FAIL wdata beat=%0d: got %h, required %h", k, mem_wdata, e.line[64*k +: 64]);
                end else passed++;
            end
            mem_resp  = 1'b1;
            mem_rdata = exp_rd ? e.line[64*k +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
        end
        mem_resp = 1'b0;
        resp_cyc = cyc;
        total++;
        if (i_pmem_resp !== (e.side == 0) || d_pmem_resp !== (e.side != 0)) begin
            $display("FAIL resp_side side=%0d: i_resp=%b d_resp=%b, required i_resp=%b d_resp=%b",
                     e.side, i_pmem_resp, d_pmem_resp, e.side == 0, e.side != 0);
        end else passed++;
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            $display("FAIL done_strobes: rd=%b wr=%b, required 0 0", mem_read, mem_write);
        end else passed++;
        if (exp_rd) begin
            rd = (e.side == 0) ? i_pmem_rdata : d_pmem_rdata;
            total++;
            if (rd !== e.line) begin
                $display("FAIL rdata side=%0d: got %h, required %h", e.side, rd, e.line);
            end else passed++;
        end
        tick();
        total++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            $display("FAIL resp_pulse: i_resp=%b d_resp=%b one cycle after DONE, required 0 0",
                     i_pmem_resp, d_pmem_resp);
        end else passed++;
        if (!keep) begin
            case (e.side)
                0:       i_pmem_read  = 1'b0;
                1:       d_pmem_read  = 1'b0;
                default: d_pmem_write = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        tick();
        tick();
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            $display("FAIL reset_strobes: rd=%b wr=%b, required 0 0", mem_read, mem_write);
        end else passed++;
        total++;
        if (mem_address !== 32'd0 || mem_wdata !== 64'd0) begin
            $display("FAIL reset_addr_wdata: addr=%h wdata=%h, required 0 0", mem_address, mem_wdata);
        end else passed++;
        total++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            $display("FAIL reset_resp: i=%b d=%b, required 0 0", i_pmem_resp, d_pmem_resp);
        end else passed++;
        total++;
        if (i_pmem_rdata !== 256'd0 || d_pmem_rdata !== 256'd0) begin
            $display("FAIL reset_rdata: i=%h d=%h, required 0", i_pmem_rdata, d_pmem_rdata);
        end else passed++;
        rst = 1'b0;
        // A stray beat strobe in IDLE must not start or advance anything.
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        tick();
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            $display("FAIL idle_mem_resp: rd=%b wr=%b i=%b d=%b, required all 0",
                     mem_read, mem_write, i_pmem_resp, d_pmem_resp);
        end else passed++;
    endtask

    task automatic test_conflict();
        for (int r = 0; r < 2; r++) begin
            i_pmem_address = 32'h0000_0100 + r * 32'h40;
            d_pmem_address = 32'h0000_0200 + r * 32'h40;
            i_pmem_read = 1'b1;
            d_pmem_read = 1'b1;
            push(1, d_pmem_address, mk_line(64'hD0 + r, 64'hD1, 64'hD2, 64'hD3));
            push(0, i_pmem_address, mk_line(64'hE0 + r, 64'hE1, 64'hE2, 64'hE3));
            serve(0, 1'b0);
            serve(0, 1'b0);
        end
    endtask

    task automatic test_icache_read();
        int t0;
        i_pmem_address = 32'h0000_1234;
        i_pmem_read    = 1'b1;
        push(0, 32'h0000_1234, mk_line({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}));
        t0 = cyc;
        serve(0, 1'b0);
        total++;
        if (resp_cyc - t0 != 5) begin
            $display("FAIL icache_latency: resp at t+%0d, required t+5", resp_cyc - t0);
        end else passed++;
    endtask

    task automatic test_writeback();
        d_pmem_address = 32'h8000_00E0;
        d_pmem_wdata   = mk_line(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        d_pmem_write   = 1'b1;
        push(2, 32'h8000_00E0, d_pmem_wdata);
        tick();
        d_pmem_wdata   = ~d_pmem_wdata;
        serve(0, 1'b0);
    endtask

    task automatic test_gaps();
        int t0;
        d_pmem_address = 32'h0000_4040;
        d_pmem_read    = 1'b1;
        push(1, 32'h0000_4040, mk_line(64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                                       64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738));
        t0 = cyc;
        tick();
        d_pmem_address = 32'hFFFF_FFFF;
        serve(2, 1'b0);
        total++;
        if (resp_cyc - t0 != 13) begin
            $display("FAIL gap_latency: resp at t+%0d, required t+13", resp_cyc - t0);
        end else passed++;
    endtask

    task automatic test_reset_mid_burst();
        i_pmem_address = 32'h0000_2000;
        i_pmem_read    = 1'b1;
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 64'h5555_5555_5555_5555;
        tick();
        mem_rdata = 64'h6666_6666_6666_6666;
        tick();
        mem_resp = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        total++;
        if (mem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
            $display("FAIL reset_mid_burst: rd=%b i_resp=%b, required 0 0", mem_read, i_pmem_resp);
        end else passed++;
        push(0, 32'h0000_2000, mk_line(64'h7070_7070_7070_7070, 64'h7171_7171_7171_7171,
                                       64'h7272_7272_7272_7272, 64'h7373_7373_7373_7373));
        serve(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        i_pmem_address = 32'h0000_3000;
        i_pmem_read    = 1'b1;
        push(0, 32'h0000_3000, mk_line(64'h1, 64'h2, 64'h3, 64'h4));
        serve(0, 1'b1);
        i_pmem_address = 32'h0000_3020;
        push(0, 32'h0000_3020, mk_line(64'h5, 64'h6, 64'h7, 64'h8));
        tick();
        total++;
        if (mem_read !== 1'b1 || cyc - resp_cyc != 2) begin
            $display("FAIL back_to_back: mem_read=%b at resp+%0d, required 1 at resp+2",
                     mem_read, cyc - resp_cyc);
        end else passed++;
        serve(0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_conflict();
        test_icache_read();
        test_writeback();
        test_gaps();
        test_reset_mid_burst();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
